// File: rtl/dnn_sched_pkg.sv
// Shared types and constants for the dnn_pipe frame scheduler.
package dnn_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        POLL,
        POLL_CHK,
        FETCH,
        DRAIN,
        START,
        WAIT_IN,
        WAIT_RES,
        WR_RES,
        CLR
    } state_t;

    localparam logic [31:0] FLAG_READY = 32'hFFFF_FFFF;
    localparam logic [31:0] FLAG_EMPTY = 32'h0000_0000;
    localparam logic [3:0]  ERR_CLASS  = 4'hF;

endpackage

// File: rtl/dnn_frame_sched_unpack.sv
// Inserts one 32-bit BRAM word into the frame register; word 0 lands in the top bits.
module frame_unpack #(
    parameter int WIDTH  = 8,
    parameter int INNODE = 784,
    parameter int IDX_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_cap_en,
    input  logic [IDX_W-1:0]          i_cap_idx,
    input  logic [31:0]               i_word,
    output logic [WIDTH*INNODE-1:0]   o_image
);

    localparam int IMG_W  = WIDTH * INNODE;
    localparam int BASE_W = $clog2(IMG_W);

    logic [BASE_W-1:0]  w_base;
    logic [IMG_W-1:0]   r_image;

    assign w_base  = BASE_W'(IMG_W - 32 * (int'(i_cap_idx) + 1));
    assign o_image = r_image;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_image <= '0;
        end else if (i_cap_en) begin
            r_image[w_base +: 32] <= i_word;
        end
    end

endmodule

// File: rtl/dnn_frame_sched.sv
// Polls the host mailbox, fetches a frame from BRAM, runs dnn_pipe and posts the class back.
module dnn_frame_sched
    import dnn_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int INNODE    = 784,
    parameter int NWORDS    = INNODE * WIDTH / 32,
    parameter int FLAG_ADDR = NWORDS,
    parameter int RES_ADDR  = NWORDS + 1,
    parameter int OUTW      = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic [7:0]               bram_addr,
    output logic                     bram_we,
    output logic [31:0]              bram_din,
    input  logic [31:0]              bram_dout,
    output logic [WIDTH*INNODE-1:0]  image,
    output logic                     dnn_start,
    input  logic                     dnn_getinput,
    input  logic                     dnn_valid,
    input  logic [OUTW-1:0]          dnn_out,
    output logic                     busy,
    output logic [15:0]              frame_cnt,
    output logic                     timeout_err
);

    localparam int         IDX_W    = $clog2(NWORDS);
    localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_widx;
    logic                r_cap;
    logic [IDX_W-1:0]    r_cap_idx;
    logic                r_got_in;
    logic [15:0]         r_wdog;
    logic [15:0]         r_frame_cnt;
    logic                r_timeout_err;
    logic [OUTW-1:0]     r_class;
    logic                w_take_valid;
    logic                w_wdog_fire;

    assign w_take_valid = dnn_valid && (r_state == WAIT_IN || r_state == WAIT_RES);
    assign w_wdog_fire  = (r_state == WAIT_RES) && !dnn_valid && (r_wdog == WDOG_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_widx        <= '0;
            r_cap         <= 1'b0;
            r_cap_idx     <= '0;
            r_got_in      <= 1'b0;
            r_wdog        <= '0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // Capture trails the issued address by one cycle to match BRAM read latency.
            r_cap     <= (r_state == FETCH);
            r_cap_idx <= r_widx;
            case (r_state)
                IDLE:     if (enable) r_state <= POLL;
                POLL:     r_state <= POLL_CHK;
                POLL_CHK: begin
                    if (bram_dout == FLAG_READY) begin
                        r_state <= FETCH;
                        r_widx  <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FETCH: begin
                    if (r_widx == IDX_W'(NWORDS - 1)) r_state <= DRAIN;
                    else r_widx <= r_widx + 1'b1;
                end
                DRAIN:    r_state <= START;
                START: begin
                    r_got_in <= dnn_getinput;
                    r_state  <= WAIT_IN;
                end
                WAIT_IN: begin
                    if (dnn_valid) begin
                        r_state <= WR_RES;
                    end else if (dnn_getinput || r_got_in) begin
                        r_state <= WAIT_RES;
                        r_wdog  <= '0;
                    end
                end
                WAIT_RES: begin
                    if (dnn_valid) begin
                        r_state <= WR_RES;
                    end else if (w_wdog_fire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= WR_RES;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                WR_RES:   r_state <= CLR;
                CLR: begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_state     <= IDLE;
                end
                default:  r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_take_valid) r_class <= dnn_out;
        else if (w_wdog_fire) r_class <= OUTW'(ERR_CLASS);
    end

    always_comb begin
        bram_addr = '0;
        bram_we   = 1'b0;
        bram_din  = '0;
        case (r_state)
            POLL:   bram_addr = 8'(FLAG_ADDR);
            FETCH:  bram_addr = 8'(r_widx);
            WR_RES: begin
                bram_we   = 1'b1;
                bram_addr = 8'(RES_ADDR);
                bram_din  = 32'(r_class);
            end
            CLR: begin
                bram_we   = 1'b1;
                bram_addr = 8'(FLAG_ADDR);
                bram_din  = FLAG_EMPTY;
            end
            default: ;
        endcase
    end

    assign dnn_start   = (r_state == START);
    assign busy        = !(r_state == IDLE || r_state == POLL || r_state == POLL_CHK);
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;

    frame_unpack #(
        .WIDTH  (WIDTH),
        .INNODE (INNODE),
        .IDX_W  (IDX_W)
    ) u_unpack (
        .clk       (clk),
        .reset     (reset),
        .i_cap_en  (r_cap),
        .i_cap_idx (r_cap_idx),
        .i_word    (bram_dout),
        .o_image   (image)
    );

endmodule
